muldiv_unit: RTL and testbench

// - Iterative RV32M multiply/divide unit between register-file read ports and write port.
// - Consumes RD1/RD2 operands and produces a writeback value, destination and write-enable
//   for WD3/A3/WE3 (through the writeback mux).
// - One operation in flight at a time; the pipeline stalls on busy.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Operand/request and writeback bundle between the pipeline and the RV32M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] result;

  modport master (
    output start, kill, funct3, rs1_data, rs2_data, rd_in,
    input  busy, done, wb_we, wb_rd, result
  );

  modport slave (
    input  start, kill, funct3, rs1_data, rs2_data, rd_in,
    output busy, done, wb_we, wb_rd, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one op in flight.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [4:0]      r_rd;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_b;
  logic            r_neg_p, r_neg_r;
  logic            r_busy, r_done;
  logic [XLEN-1:0] r_result;

  // Operand decode on the live request; only used while idle.
  logic            w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div0, w_ovf, w_quick;
  logic [XLEN-1:0] w_quick_res;

  assign w_a_sgn = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                   (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
  assign w_b_sgn = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
  assign w_a_neg = w_a_sgn & bus.rs1_data[XLEN-1];
  assign w_b_neg = w_b_sgn & bus.rs2_data[XLEN-1];
  assign w_a_mag = w_a_neg ? -bus.rs1_data : bus.rs1_data;
  assign w_b_mag = w_b_neg ? -bus.rs2_data : bus.rs2_data;
  assign w_div0  = bus.funct3[2] && (bus.rs2_data == '0);
  assign w_ovf   = ((bus.funct3 == 3'd4) || (bus.funct3 == 3'd6)) &&
                   (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_data == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_mag, w_fast_s;
  assign w_fast_mag = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
  assign w_fast_s   = (w_a_neg ^ w_b_neg) ? -w_fast_mag : w_fast_mag;
  assign w_quick    = w_div0 || w_ovf || !bus.funct3[2];
`else
  assign w_quick    = w_div0 || w_ovf;
`endif

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_quick_res = '0;
    if (w_div0)
      w_quick_res = bus.funct3[1] ? bus.rs1_data : '1;
    else if (w_ovf)
      w_quick_res = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
    else if (!bus.funct3[2])
      w_quick_res = (bus.funct3 == 3'd0) ? w_fast_s[XLEN-1:0] : w_fast_s[2*XLEN-1:XLEN];
`endif
  end

  // One radix-2 step. Multiply: {hi,lo} shifts right, multiplier in lo.
  // Divide: remainder in hi, dividend shifts out of lo as quotient shifts in.
  logic [XLEN:0]     w_msum, w_dtrial, w_ddiff;
  logic [XLEN-1:0]   w_next_hi, w_next_lo, w_rem_s, w_quo_s;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_final;

  assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_dtrial = {r_hi, r_lo[XLEN-1]};
  assign w_ddiff  = w_dtrial - {1'b0, r_b};

  always_comb begin
    w_next_hi = w_msum[XLEN:1];
    w_next_lo = {w_msum[0], r_lo[XLEN-1:1]};
    if (r_op[2]) begin
      w_next_hi = w_ddiff[XLEN] ? w_dtrial[XLEN-1:0] : w_ddiff[XLEN-1:0];
      w_next_lo = {r_lo[XLEN-2:0], ~w_ddiff[XLEN]};
    end
  end

  assign w_prod   = {w_next_hi, w_next_lo};
  assign w_prod_s = r_neg_p ? -w_prod : w_prod;
  assign w_quo_s  = r_neg_p ? -w_next_lo : w_next_lo;
  assign w_rem_s  = r_neg_r ? -w_next_hi : w_next_hi;

  always_comb begin
    w_final = w_prod_s[2*XLEN-1:XLEN];
    if (r_op[2])
      w_final = r_op[1] ? w_rem_s : w_quo_s;
    else if (r_op[1:0] == 2'd0)
      w_final = w_prod_s[XLEN-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_neg_p  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start && !bus.kill) begin
            r_op    <= bus.funct3;
            r_rd    <= bus.rd_in;
            r_cnt   <= '0;
            r_neg_p <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_quick) begin
              r_state  <= S_FIN;
              r_done   <= 1'b1;
              r_result <= w_quick_res;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_hi    <= '0;
              r_lo    <= bus.funct3[2] ? w_a_mag : w_b_mag;
              r_b     <= bus.funct3[2] ? w_b_mag : w_a_mag;
            end
          end
        end
        S_RUN: begin
          if (bus.kill) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hi  <= w_next_hi;
            r_lo  <= w_next_lo;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'(XLEN-1)) begin
              r_state  <= S_FIN;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= w_final;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A flush landing in the completion cycle suppresses the writeback.
  assign bus.busy   = r_busy;
  assign bus.done   = r_done & ~bus.kill;
  assign bus.wb_we  = r_done & ~bus.kill;
  assign bus.wb_rd  = r_rd;
  assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, special cases, kill and reset.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, count edges to done (start edge = 1), check result/writeback and single pulse.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int exp_lat,
                        input logic [31:0] exp_res);
    int n;
    @(negedge clk);
    bus.funct3 = f; bus.rs1_data = a; bus.rs2_data = b; bus.rd_in = rd; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    check({tag, " busy"}, {31'd0, bus.busy}, {31'd0, exp_lat > 1});
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " wb_rd"}, {27'd0, bus.wb_rd}, {27'd0, rd});
    check({tag, " wb_we"}, {31'd0, bus.wb_we}, 32'd1);
    @(posedge clk); #1;
    check({tag, " done pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_done;
    rst = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_in = '0;
    #12;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset wb_we", {31'd0, bus.wb_we}, 32'd0);
    check("reset wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    check("reset result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("MUL", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, MUL_LAT, 32'hFFFF_FFEB);
    run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, MUL_LAT, 32'hFFFF_FFFE);
    run_op("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, MUL_LAT, 32'h0000_0000);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, MUL_LAT, 32'hFFFF_FFFF);
    run_op("DIV", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, DIV_LAT, 32'hFFFF_FFFD);
    run_op("REM", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, DIV_LAT, 32'hFFFF_FFFF);
    run_op("DIVU", 3'd5, 32'd100, 32'd7, 5'd6, DIV_LAT, 32'd14);
    run_op("REMU", 3'd7, 32'd100, 32'd7, 5'd7, DIV_LAT, 32'd2);
    run_op("DIVU by 0", 3'd5, 32'd5, 32'd0, 5'd8, 1, 32'hFFFF_FFFF);
    run_op("REM by 0", 3'd6, 32'd5, 32'd0, 5'd10, 1, 32'd5);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1, 32'h8000_0000);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1, 32'd0);

    // DIVU 1000/3: second start at edge 5 ignored, kill at edge 10.
    @(negedge clk);
    bus.funct3 = 3'd5; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd3; bus.rd_in = 5'd13;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    saw_done = 1'b0;
    for (int e = 2; e <= 10; e++) begin
      @(negedge clk);
      if (e == 5) begin
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd2; bus.rs2_data = 32'd2;
      end
      if (e == 10) bus.kill = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.kill = 1'b0;
      if (e == 9) check("busy before kill", {31'd0, bus.busy}, 32'd1);
      saw_done |= bus.done;
    end
    check("busy after kill", {31'd0, bus.busy}, 32'd0);
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      saw_done |= bus.done;
    end
    check("no done after kill", {31'd0, saw_done}, 32'd0);
    check("result kept after kill", bus.result, 32'd0);
    run_op("MUL after kill", 3'd0, 32'd3, 32'd4, 5'd14, MUL_LAT, 32'd12);

    // Async reset in the middle of a divide.
    @(negedge clk);
    bus.funct3 = 3'd5; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7; bus.rd_in = 5'd15;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst done", {31'd0, bus.done}, 32'd0);
    check("rst wb_we", {31'd0, bus.wb_we}, 32'd0);
    check("rst result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("REMU after rst", 3'd7, 32'd100, 32'd7, 5'd16, DIV_LAT, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
